cpu_step_ctrl: RTL
==================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 The block SHALL have parameter BURST_W, default 8, giving the burst-length width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the enabled-cycle counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset, sampled only on rising clk).
REQ-005 The block SHALL have port btn_step, input, 1 bit: one-cycle pulse from a debounced button edge detector, requesting a single step.
REQ-006 The block SHALL have port btn_run, input, 1 bit: one-cycle pulse toggling free-run.
REQ-007 The block SHALL have port btn_burst, input, 1 bit: one-cycle pulse requesting a burst of burst_len cycles.
REQ-008 The block SHALL have port burst_len, input, BURST_W bits: requested burst length, sampled only when a burst is accepted.
REQ-009 The block SHALL have port halt_in, input, 1 bit: level from the CPU (e.g. ebreak) forcing a pause.
REQ-010 The block SHALL have port cpu_en, output, 1 bit: registered CPU clock-enable.
REQ-011 The block SHALL have port mode, output, 2 bits: current state encoding (PAUSE=0, STEP=1, BURST=2, RUN=3).
REQ-012 The block SHALL have port burst_rem, output, BURST_W bits: burst cycles still to issue, including the current one.
REQ-013 The block SHALL have port cycle_cnt, output, CNT_W bits: total number of cycles with cpu_en=1.

Function
REQ-014 The block SHALL hold a four-state FSM (PAUSE, STEP, BURST, RUN) and SHALL drive cpu_en=1 exactly in the cycles when the registered state is STEP, BURST or RUN.
REQ-015 The block SHALL assert cpu_en in the cycle after an accepted request, giving a latency of exactly one clock from the request pulse.
REQ-016 In PAUSE, the block SHALL prioritise simultaneous pulses as btn_run > btn_burst > btn_step, accept only the highest-priority pulse and drop the others.
REQ-017 In PAUSE, on btn_run with halt_in=0, the block SHALL go to RUN; with halt_in=1 it SHALL ignore the request and stay in PAUSE.
REQ-018 In PAUSE, on btn_burst with halt_in=0 and burst_len!=0, the block SHALL go to BURST and latch burst_rem=burst_len.
REQ-019 In PAUSE, the block SHALL ignore btn_burst when burst_len==0 or halt_in=1, and SHALL then consider a simultaneous btn_step.
REQ-020 In PAUSE, on btn_step, the block SHALL go to STEP regardless of halt_in, so the user can step past a halt.
REQ-021 The block SHALL leave STEP after one cycle, unconditionally returning to PAUSE; pulses arriving during STEP SHALL be ignored.
REQ-022 In BURST, the block SHALL decrement burst_rem by 1 each cycle and SHALL return to PAUSE in the cycle after burst_rem==1, giving exactly burst_len cpu_en cycles.
REQ-023 In BURST, btn_run or halt_in=1 SHALL abort to PAUSE next cycle, clear burst_rem to 0, and give no further cpu_en cycles.
REQ-024 In BURST, btn_step and btn_burst SHALL be ignored.
REQ-025 In RUN, the block SHALL remain in RUN until btn_run or halt_in=1, then go to PAUSE next cycle; btn_step and btn_burst SHALL be ignored.
REQ-026 The block SHALL hold burst_rem at 0 outside BURST.
REQ-027 The block SHALL increment cycle_cnt by 1 in every cycle with cpu_en=1, and cycle_cnt SHALL wrap modulo 2^CNT_W (all-ones +1 -> 0).
REQ-028 The block SHALL latch burst_len at full width, so the maximum burst is 2^BURST_W-1 cycles.

Reset
REQ-029 While rst=0 at a rising clk edge, the block SHALL set state=PAUSE, cpu_en=0, mode=0, burst_rem=0 and cycle_cnt=0, and SHALL ignore all pulses in that cycle.
REQ-030 Reset asserted mid-BURST or mid-RUN SHALL drop cpu_en in the next cycle, with no partial burst resumed after release.
REQ-031 The block SHALL have no asynchronous path from rst to any output.

Verification
REQ-032 The bench SHALL check a single step: in PAUSE, pulse btn_step at cycle N -> cpu_en=1 only at N+1, mode=1 at N+1, mode=0 at N+2, cycle_cnt=1.
REQ-033 The bench SHALL check a burst: burst_len=5, pulse btn_burst -> cpu_en=1 for exactly 5 consecutive cycles, burst_rem 5,4,3,2,1 then 0, cycle_cnt=5.
REQ-034 The bench SHALL check run and halt: pulse btn_run, wait 10 cycles, raise halt_in -> cpu_en low the next cycle, mode=0, and a btn_run during halt_in=1 is ignored, while btn_step still gives one cycle.
REQ-035 The bench SHALL check simultaneous pulses: btn_run, btn_burst and btn_step in the same PAUSE cycle -> mode=3; separately, burst_len=0 with btn_burst+btn_step -> STEP.
REQ-036 The bench SHALL check burst abort and reset: burst_len=200 aborted by btn_run after 3 cycles -> 3 cpu_en cycles, burst_rem=0; rst=0 during RUN -> all outputs 0 the next cycle.
REQ-037 The bench SHALL check wrap: with CNT_W=4, issue 17 enabled cycles -> cycle_cnt=1.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: single-step / burst / free-run clock-enable controller for a debug CPU.
module cpu_step_ctrl #(
  parameter int BURST_W = 8,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic               btn_burst,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_in,
  output logic               cpu_en,
  output logic [1:0]         mode,
  output logic [BURST_W-1:0] burst_rem,
  output logic [CNT_W-1:0]   cycle_cnt
);
  typedef enum logic [1:0] {PAUSE = 2'd0, STEP = 2'd1, BURST = 2'd2, RUN = 2'd3} state_t;
  state_t state, nxt;
  logic [BURST_W-1:0] rem_nxt;
  logic burst_ok;
  assign mode = state;
  assign burst_ok = btn_burst && !halt_in && burst_len != '0;
  always_comb begin
    nxt = PAUSE;
    rem_nxt = '0;
    case (state)
      PAUSE: begin
        // a present btn_run wins even when halt blocks it; the others are dropped
        nxt = btn_run ? (halt_in ? PAUSE : RUN) : burst_ok ? BURST : btn_step ? STEP : PAUSE;
        rem_nxt = (!btn_run && burst_ok) ? burst_len : '0;
      end
      BURST: begin
        nxt = (btn_run || halt_in || burst_rem == BURST_W'(1)) ? PAUSE : BURST;
        rem_nxt = (nxt == BURST) ? burst_rem - BURST_W'(1) : '0;
      end
      RUN: nxt = (btn_run || halt_in) ? PAUSE : RUN;
      default: nxt = PAUSE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= PAUSE;
      cpu_en <= 1'b0;
      burst_rem <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= nxt;
      cpu_en <= nxt != PAUSE;
      burst_rem <= rem_nxt;
      cycle_cnt <= cycle_cnt + CNT_W'(cpu_en);
    end
  end
endmodule
